// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: per-stage stall/bubble/flush decode with blocked-flush latch, stall watchdog and perf counters
module pipe_hazard_ctrl #(
  parameter int NSTAGE  = 6,
  parameter int ADDR_W  = 32,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NSTAGE-1:0]        stall_req,
  input  logic [NSTAGE-1:0]        flush_req,
  input  logic [NSTAGE*ADDR_W-1:0] flush_target,
  output logic [NSTAGE-1:0]        stall_state,
  output logic [NSTAGE-1:0]        bubble,
  output logic [NSTAGE-1:0]        flush,
  output logic                     redirect_valid,
  output logic [ADDR_W-1:0]        redirect_pc,
  output logic                     flush_pending,
  output logic                     stall_timeout,
  output logic [CNT_W-1:0]         stall_cycles,
  output logic [CNT_W-1:0]         flush_count
);
  localparam int SW = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;
  localparam int WW = $clog2(TIMEOUT);
  logic              pend_v_q, timeout_q;
  logic [SW-1:0]     pend_src_q;
  logic [ADDR_W-1:0] pend_tgt_q;
  logic [WW-1:0]     wd_q;
  logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;
  logic              new_v, use_new, cand_v, issue, any_stall;
  logic [SW-1:0]     new_src, cand_src, k;
  logic [ADDR_W-1:0] new_tgt, cand_tgt;
  logic [NSTAGE-1:0] kill, eff;
  // Issue is decided on raw requests; the stall decode then only sees stages that survive the flush.
  always_comb begin
    new_v = |flush_req;
    new_src = '0;
    for (int i = 0; i < NSTAGE; i++) if (flush_req[i]) new_src = SW'(i);
    new_tgt = flush_target[new_src*ADDR_W +: ADDR_W];
    use_new = new_v && (!pend_v_q || new_src >= pend_src_q);
    cand_v = new_v || pend_v_q;
    cand_src = use_new ? new_src : pend_src_q;
    cand_tgt = use_new ? new_tgt : pend_tgt_q;
    issue = cand_v && !(|(stall_req >> cand_src));
    kill = '0;
    for (int m = 0; m < NSTAGE; m++) kill[m] = issue && (m < int'(cand_src));
    eff = stall_req & ~kill;
    k = '0;
    for (int i = 0; i < NSTAGE; i++) if (eff[i]) k = SW'(i);
    stall_state = '0;
    bubble = '0;
    for (int i = 0; i < NSTAGE; i++) begin
      stall_state[i] = |eff && (SW'(i) <= k);
      bubble[i] = |eff && (i == int'(k) + 1);
    end
    flush = kill;
    redirect_valid = issue;
    redirect_pc = issue ? cand_tgt : '0;
    if (rst) begin
      stall_state = '1;
      bubble = '0;
      flush = '0;
      redirect_valid = 1'b0;
      redirect_pc = '0;
    end
    any_stall = |stall_state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_v_q <= 1'b0;
      pend_src_q <= '0;
      pend_tgt_q <= '0;
      wd_q <= '0;
      timeout_q <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      pend_v_q <= cand_v && !issue;
      pend_src_q <= cand_src;
      pend_tgt_q <= cand_tgt;
      wd_q <= !any_stall ? '0 : (wd_q == WW'(TIMEOUT-1)) ? wd_q : wd_q + 1'b1;
      if (any_stall && wd_q >= WW'(TIMEOUT-2)) timeout_q <= 1'b1;
      if (any_stall && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (redirect_valid && !(&flush_cnt_q)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end
  assign flush_pending = pend_v_q;
  assign stall_timeout = timeout_q;
  assign stall_cycles = stall_cnt_q;
  assign flush_count = flush_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed plus random checks of pipe_hazard_ctrl against a run-length/priority reference model
module tb_pipe_hazard_ctrl;
  localparam int N = 6, AW = 32, CW = 32, TO = 8;
  logic clk = 0, rst = 1;
  logic [N-1:0] stall_req = '0, flush_req = '0;
  logic [N*AW-1:0] flush_target = '0;
  logic [N-1:0] stall_state, bubble, flush;
  logic redirect_valid, flush_pending, stall_timeout;
  logic [AW-1:0] redirect_pc;
  logic [CW-1:0] stall_cycles, flush_count;
  pipe_hazard_ctrl #(.NSTAGE(N), .ADDR_W(AW), .CNT_W(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .stall_req(stall_req), .flush_req(flush_req), .flush_target(flush_target),
    .stall_state(stall_state), .bubble(bubble), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .flush_pending(flush_pending), .stall_timeout(stall_timeout),
    .stall_cycles(stall_cycles), .flush_count(flush_count));
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  logic [AW-1:0] tg [N];
  bit mp_v = 0, mt = 0;
  int mp_src = 0, run = 0;
  logic [AW-1:0] mp_tgt = '0;
  longint msc = 0, mfc = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic int top(input logic [N-1:0] v);
    int r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction
  // Drive one cycle after the falling edge, check every output, then advance the model past the rising edge.
  task automatic step(input logic r, input logic [N-1:0] st, input logic [N-1:0] fl);
    int ks, s, c;
    bit cv, iss;
    logic [AW-1:0] ct, epc;
    logic [N-1:0] ess, ebu, efl;
    @(negedge clk);
    rst = r;
    stall_req = st;
    flush_req = fl;
    for (int i = 0; i < N; i++) flush_target[i*AW +: AW] = tg[i];
    #1;
    ks = top(st);
    s = top(fl);
    cv = 0; c = 0; ct = '0;
    if (s >= 0 && (!mp_v || s >= mp_src)) begin cv = 1; c = s; ct = tg[s]; end
    else if (mp_v) begin cv = 1; c = mp_src; ct = mp_tgt; end
    iss = cv && ((st >> c) == 0);
    ess = '0; ebu = '0; efl = '0; epc = '0;
    if (ks >= 0) ess = N'((1 << (ks + 1)) - 1);
    if (ks >= 0 && ks < N - 1) ebu = N'(1 << (ks + 1));
    if (iss) begin ess = '0; ebu = '0; efl = N'((1 << c) - 1); epc = ct; end
    if (r) begin ess = '1; ebu = '0; efl = '0; epc = '0; iss = 0; end
    chk("stall_state", 64'(stall_state), 64'(ess));
    chk("bubble", 64'(bubble), 64'(ebu));
    chk("flush", 64'(flush), 64'(efl));
    chk("redirect_valid", 64'(redirect_valid), 64'(iss));
    chk("redirect_pc", 64'(redirect_pc), 64'(epc));
    chk("flush_pending", 64'(flush_pending), 64'(mp_v));
    chk("stall_timeout", 64'(stall_timeout), 64'(mt));
    chk("stall_cycles", 64'(stall_cycles), 64'(msc));
    chk("flush_count", 64'(flush_count), 64'(mfc));
    if (r) begin
      mp_v = 0; run = 0; mt = 0; msc = 0; mfc = 0;
    end else begin
      mp_v = cv && !iss;
      if (mp_v) begin mp_src = c; mp_tgt = ct; end
      if (ess != 0) begin run++; msc++; if (run >= TO - 1) mt = 1; end else run = 0;
      if (iss) mfc++;
    end
  endtask
  initial begin
    for (int i = 0; i < N; i++) tg[i] = $urandom;
    step(1, N'($urandom), N'($urandom));
    step(1, N'($urandom), N'($urandom));
    chk("rst_stall_all", 64'(stall_state), 64'h3f);
    step(0, '0, '0);
    chk("idle_after_rst", 64'(stall_state), 64'h0);
    step(0, 6'b010100, '0);
    chk("prio_ss_a", 64'(stall_state), 64'h1f);
    chk("prio_bub_a", 64'(bubble), 64'h20);
    step(0, 6'b000010, '0);
    chk("prio_ss_b", 64'(stall_state), 64'h03);
    chk("prio_bub_b", 64'(bubble), 64'h04);
    step(0, '0, '0);
    chk("stall_cycles_2", 64'(stall_cycles), 64'd2);
    tg[3] = 32'h8000_0040;
    step(0, 6'b000001, 6'b001000);
    chk("unblk_flush", 64'(flush), 64'h07);
    chk("unblk_pc", 64'(redirect_pc), 64'h8000_0040);
    step(0, '0, '0);
    chk("flush_count_1", 64'(flush_count), 64'd1);
    tg[2] = 32'h100;
    step(0, 6'b010000, 6'b000100);
    step(0, 6'b010000, '0);
    step(0, 6'b010000, '0);
    chk("blk_pending", 64'(flush_pending), 64'd1);
    chk("blk_no_redirect", 64'(redirect_valid), 64'd0);
    step(0, '0, '0);
    chk("blk_issue_flush", 64'(flush), 64'h03);
    chk("blk_issue_pc", 64'(redirect_pc), 64'h100);
    step(0, '0, '0);
    chk("blk_pending_clr", 64'(flush_pending), 64'd0);
    tg[3] = 32'h200;
    step(0, 6'b010000, 6'b000100);
    step(0, 6'b010000, 6'b001000);
    step(0, '0, '0);
    chk("ovr_deeper_flush", 64'(flush), 64'h07);
    chk("ovr_deeper_pc", 64'(redirect_pc), 64'h200);
    tg[1] = 32'h300;
    step(0, 6'b010000, 6'b000100);
    step(0, 6'b010000, 6'b000010);
    step(0, '0, '0);
    chk("ovr_shallow_flush", 64'(flush), 64'h03);
    chk("ovr_shallow_pc", 64'(redirect_pc), 64'h100);
    step(1, '0, '0);
    step(0, '0, '0);
    repeat (6) step(0, 6'b010000, '0);
    step(0, '0, '0);
    chk("wd_6_clear", 64'(stall_timeout), 64'd0);
    repeat (7) step(0, 6'b010000, '0);
    step(0, '0, '0);
    chk("wd_7_set", 64'(stall_timeout), 64'd1);
    repeat (3) step(0, '0, '0);
    chk("wd_sticky", 64'(stall_timeout), 64'd1);
    step(1, '0, '0);
    step(0, '0, '0);
    chk("wd_rst_clear", 64'(stall_timeout), 64'd0);
    for (int n = 0; n < 600; n++) begin
      logic [N-1:0] st, fl;
      for (int i = 0; i < N; i++) tg[i] = $urandom;
      st = ($urandom % 3 == 0) ? N'($urandom) : '0;
      if (n >= 300 && n < 320) st = 6'b000100;
      fl = ($urandom % 3 == 0) ? N'($urandom) : '0;
      step(($urandom % 80) == 0, st, fl);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
